alu_muldiv_seq: RTL and testbench

- Parametrised multi-cycle arithmetic unit that extends the single-cycle ALU with RV32M multiply/divide (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the ALU in the execute stage.
- Takes operands through a valid/ready handshake, computes iteratively, and returns the result with a destination tag so writeback can match it to its instruction.

---
 rtl/alu_muldiv_seq_if.sv | 35 +++
 rtl/alu_muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq_if
//  Description : Request/response bundle for the iterative RV32M mul/div unit.
//                The master issues operations and accepts results; the slave
//                is the arithmetic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_seq_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  operand_a;
   logic [XLEN-1:0]  operand_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  result;
   logic [TAG_W-1:0] out_tag;
   logic             div_by_zero;

   modport master (
      output in_valid, funct3, operand_a, operand_b, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag, div_by_zero
   );

   modport slave (
      input  in_valid, funct3, operand_a, operand_b, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : Multi-cycle RV32M multiply/divide unit. Operands are reduced
//                to magnitudes on acceptance, processed one bit per cycle
//                (shift-add multiply, restoring divide) and sign-corrected in
//                a single fix-up cycle. The result is held with its tag until
//                the consumer accepts it.
//                Optional macro MULDIV_FAST_MUL_EN: multiplies skip the
//                iterative loop and use a registered combinational multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   alu_muldiv_seq_if.slave bus,
   output logic            busy
);

   localparam int                 C_CNT_W    = $clog2(XLEN);
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(XLEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [C_CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic                neg_a_q, neg_a_d;
   logic                neg_b_q, neg_b_d;
   logic                bzero_q, bzero_d;
   // Multiplicand (multiply) or divisor (divide) magnitude.
   logic [XLEN-1:0]     opnd_q, opnd_d;
   // Multiply: {partial product high, multiplier/product low}.
   // Divide:   {partial remainder, dividend/quotient}.
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [TAG_W-1:0]    out_tag_q, out_tag_d;
   logic                dbz_q, dbz_d;
   logic                out_valid_q, out_valid_d;

   logic                w_accept;
   logic                w_sgn_a, w_sgn_b;
   logic                w_neg_a, w_neg_b;
   logic [XLEN-1:0]     w_mag_a, w_mag_b;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_step;
   logic [XLEN:0]       w_div_trial;
   logic                w_div_ge;
   logic [XLEN-1:0]     w_div_rem;
   logic [2*XLEN-1:0]   w_div_step;
   logic [2*XLEN-1:0]   w_prod_s;
   logic [XLEN-1:0]     w_quo_s, w_rem_s;
   logic [XLEN-1:0]     w_fix_result;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0]   w_fast_prod;
`endif

   assign w_accept = bus.in_valid & bus.in_ready;

   // Operand signedness and magnitudes for the op being presented.
   always_comb begin
      w_sgn_a = 1'b0;
      w_sgn_b = 1'b0;
      case (bus.funct3)
         3'b001: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end  // MULH
         3'b010: begin w_sgn_a = 1'b1; w_sgn_b = 1'b0; end  // MULHSU
         3'b100: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end  // DIV
         3'b110: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end  // REM
         default: begin w_sgn_a = 1'b0; w_sgn_b = 1'b0; end
      endcase
      w_neg_a = w_sgn_a & bus.operand_a[XLEN-1];
      w_neg_b = w_sgn_b & bus.operand_b[XLEN-1];
      w_mag_a = w_neg_a ? (~bus.operand_a + 1'b1) : bus.operand_a;
      w_mag_b = w_neg_b ? (~bus.operand_b + 1'b1) : bus.operand_b;
   end

   // One iteration of shift-add multiply and restoring divide.
   always_comb begin
      w_mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
      w_mul_step  = {w_mul_sum, acc_q[XLEN-1:1]};
      w_div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      w_div_ge    = (w_div_trial >= {1'b0, opnd_q});
      // The true difference always fits in XLEN bits when the trial succeeds.
      w_div_rem   = w_div_ge ? (w_div_trial[XLEN-1:0] - opnd_q) : w_div_trial[XLEN-1:0];
      w_div_step  = {w_div_rem, acc_q[XLEN-2:0], w_div_ge};
   end

`ifdef MULDIV_FAST_MUL_EN
   // Single-cycle magnitude product, registered before sign correction.
   always_comb begin
      w_fast_prod = {{XLEN{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
   end
`endif

   // Sign correction and half / quotient / remainder selection.
   always_comb begin
      w_prod_s = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
      // A zero divisor yields all ones regardless of the dividend sign.
      if (bzero_q)
         w_quo_s = {XLEN{1'b1}};
      else if (neg_a_q ^ neg_b_q)
         w_quo_s = ~acc_q[XLEN-1:0] + 1'b1;
      else
         w_quo_s = acc_q[XLEN-1:0];
      w_rem_s = neg_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      if (op_q[2])
         w_fix_result = op_q[1] ? w_rem_s : w_quo_s;
      else if (op_q[1:0] == 2'b00)
         w_fix_result = w_prod_s[XLEN-1:0];
      else
         w_fix_result = w_prod_s[2*XLEN-1:XLEN];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic; flush returns to IDLE from anywhere.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
               state_d = bus.funct3[2] ? S_CALC : S_FIX;
`else
               state_d = S_CALC;
`endif
            end
         end
         S_CALC:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush)
         state_d = S_IDLE;
   end

   // State-derived outputs; a flush blocks acceptance in the same cycle.
   always_comb begin
      bus.in_ready = (state_q == S_IDLE) && !flush;
      busy         = (state_q != S_IDLE);
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.result      = result_q;
   assign bus.out_tag     = out_tag_q;
   assign bus.div_by_zero = dbz_q;

   // Datapath and output register next values.
   always_comb begin
      cnt_d       = cnt_q;
      op_d        = op_q;
      tag_d       = tag_q;
      neg_a_d     = neg_a_q;
      neg_b_d     = neg_b_q;
      bzero_d     = bzero_q;
      opnd_d      = opnd_q;
      acc_d       = acc_q;
      result_d    = result_q;
      out_tag_d   = out_tag_q;
      dbz_d       = dbz_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               op_d    = bus.funct3;
               tag_d   = bus.in_tag;
               neg_a_d = w_neg_a;
               neg_b_d = w_neg_b;
               bzero_d = (bus.operand_b == '0);
               opnd_d  = bus.funct3[2] ? w_mag_b : w_mag_a;
               acc_d   = {{XLEN{1'b0}}, (bus.funct3[2] ? w_mag_a : w_mag_b)};
               cnt_d   = C_CNT_LAST;
`ifdef MULDIV_FAST_MUL_EN
               // One FIX cycle to register the product, one to finish.
               if (!bus.funct3[2])
                  cnt_d = C_CNT_W'(1);
`endif
            end
         end
         S_CALC: begin
            acc_d = op_q[2] ? w_div_step : w_mul_step;
            if (cnt_q != '0)
               cnt_d = cnt_q - 1'b1;
         end
         S_FIX: begin
`ifdef MULDIV_FAST_MUL_EN
            if (cnt_q != '0) begin
               acc_d = w_fast_prod;
               cnt_d = cnt_q - 1'b1;
            end else begin
               result_d    = w_fix_result;
               out_tag_d   = tag_q;
               dbz_d       = op_q[2] & bzero_q;
               out_valid_d = 1'b1;
            end
`else
            result_d    = w_fix_result;
            out_tag_d   = tag_q;
            dbz_d       = op_q[2] & bzero_q;
            out_valid_d = 1'b1;
`endif
         end
         S_DONE: begin
            if (bus.out_ready)
               out_valid_d = 1'b0;
         end
         default: ;
      endcase
      if (flush)
         out_valid_d = 1'b0;
   end

   // Datapath and output registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         op_q        <= '0;
         tag_q       <= '0;
         neg_a_q     <= 1'b0;
         neg_b_q     <= 1'b0;
         bzero_q     <= 1'b0;
         opnd_q      <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         out_tag_q   <= '0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         tag_q       <= tag_d;
         neg_a_q     <= neg_a_d;
         neg_b_q     <= neg_b_d;
         bzero_q     <= bzero_d;
         opnd_q      <= opnd_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         out_tag_q   <= out_tag_d;
         dbz_q       <= dbz_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Directed-vector scoreboard bench for alu_muldiv_seq.
//                Stimulus pushes hand-computed results; a negedge monitor
//                pops and compares whenever a result is handed over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      logic        dbz;
      int          exp_cyc;
   } exp_t;

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  t;
      logic [31:0] r;
      logic        d;
   } vec_t;

   logic clk;
   logic rst;
   logic flush;
   logic busy;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t vecs [20];

   alu_muldiv_seq_if #(.XLEN(32), .TAG_W(5)) bus ();

   alu_muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present a request, wait (bounded) for acceptance, then scramble inputs.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] er, input logic edbz,
                        input bit push, output int acc);
      int   n;
      exp_t e;
      n = 0;
      bus.funct3    = f;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.in_tag    = t;
      bus.in_valid  = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 200);
      if (!bus.in_ready) begin
         chk("accept_timeout", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      bus.in_valid  = 1'b0;
      bus.operand_a = ~a;
      bus.operand_b = a ^ b ^ 32'h5A5A_A5A5;
      bus.funct3    = ~f;
      if (push) begin
         e.res     = er;
         e.tag     = t;
         e.dbz     = edbz;
         e.exp_cyc = acc + (f[2] ? DIV_LAT : MUL_LAT);
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      #1;
   endtask

   // Monitor: latency on first valid, payload on handover.
   initial begin
      bit lat_done;
      lat_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               if (!lat_done) begin
                  chk("latency", 32'(cyc), 32'(sb[0].exp_cyc));
                  lat_done = 1'b1;
               end
               if (bus.out_ready) begin
                  chk("result", bus.result, sb[0].res);
                  chk("out_tag", 32'(bus.out_tag), 32'(sb[0].tag));
                  chk("div_by_zero", 32'(bus.div_by_zero), 32'(sb[0].dbz));
                  void'(sb.pop_front());
                  lat_done = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acc;
      int  rel;
      int  n;
      bit  seen;

      vecs = '{
         '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 1'b0},
         '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 1'b0},
         '{3'b101, 32'h0000_1234, 32'h0000_0000, 5'd7,  32'hFFFF_FFFF, 1'b1},
         '{3'b111, 32'h0000_1234, 32'h0000_0000, 5'd8,  32'h0000_1234, 1'b1},
         '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1'b0},
         '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1'b0},
         '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1'b0},
         '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 1'b0},
         '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd13, 32'hFFFF_FFFF, 1'b0},
         '{3'b000, 32'h0000_0003, 32'h0000_0005, 5'd14, 32'h0000_000F, 1'b0},
         '{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 5'd15, 32'hFFFF_FFFF, 1'b1},
         '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 5'd16, 32'hFFFF_FFF9, 1'b1},
         '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'h0000_0001, 1'b0},
         '{3'b011, 32'h8000_0000, 32'h0000_0004, 5'd18, 32'h0000_0002, 1'b0},
         '{3'b101, 32'h0000_0064, 32'h0000_0007, 5'd19, 32'h0000_000E, 1'b0},
         '{3'b111, 32'h0000_0064, 32'h0000_0007, 5'd20, 32'h0000_0002, 1'b0},
         '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd21, 32'hFFFF_FFFD, 1'b0},
         '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd22, 32'h0000_0001, 1'b0},
         '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd23, 32'h4000_0000, 1'b0},
         '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h8000_0000, 1'b0}
      };

      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.funct3    = 3'b000;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.in_tag    = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
      chk("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed vectors.
      foreach (vecs[i]) begin
         issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].r, vecs[i].d, 1'b1, acc);
         drain();
      end

      // Backpressure: result must hold while out_ready is low.
      bus.out_ready = 1'b0;
      issue(3'b000, 32'd3, 32'd7, 5'd25, 32'd21, 1'b0, 1'b1, acc);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 100);
      chk("bp_valid_seen", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_result", bus.result, 32'd21);
         chk("bp_out_tag", 32'(bus.out_tag), 32'd25);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rel = cyc;
      bus.out_ready = 1'b1;
      // Request presented while still in DONE must wait for the IDLE cycle.
      issue(3'b101, 32'h0000_0055, 32'd0, 5'd26, 32'hFFFF_FFFF, 1'b1, 1'b1, acc);
      chk("bp_accept_cycle", 32'(acc), 32'(rel + 2));
      drain();

      // Flush while idle blocks acceptance.
      @(posedge clk);
      #1;
      flush         = 1'b1;
      bus.funct3    = 3'b100;
      bus.operand_a = 32'd9;
      bus.operand_b = 32'd3;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_idle_busy", 32'(busy), 32'd0);

      // Flush mid-divide: result must never appear.
      @(posedge clk);
      #1;
      issue(3'b100, 32'd100, 32'd7, 5'd27, 32'd0, 1'b0, 1'b0, acc);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_in_ready_after", 32'(bus.in_ready), 32'd1);
      chk("flush_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         seen = seen | bus.out_valid;
      end
      chk("flush_no_valid", 32'(seen), 32'd0);

      // Reset mid-divide: outputs clear, then a new request completes.
      @(posedge clk);
      #1;
      issue(3'b100, 32'd100, 32'd7, 5'd28, 32'd0, 1'b0, 1'b0, acc);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mrst_result", bus.result, 32'd0);
      chk("mrst_out_tag", 32'(bus.out_tag), 32'd0);
      chk("mrst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mrst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd30, 32'hFFFF_FFFD, 1'b0, 1'b1, acc);
      drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
